// File: rtl/gpio_uart_pkg.sv
// gpio_uart_pkg: frame constants and FSM states shared by gpio_uart_sink
package gpio_uart_pkg;
    localparam logic [7:0] HDR_BYTE = 8'h1c;
    localparam logic [7:0] ACK_BYTE = 8'h06;
    localparam logic [7:0] NAK_BYTE = 8'h15;
    localparam int PAYLOAD_BYTES = 3;
    typedef enum logic [2:0] {IDLE, PAYLOAD, CHECK, SEND, WAIT} state_t;
endpackage

// File: rtl/gpio_uart_sink_if.sv
// gpio_uart_sink_if: Uart byte handshake plus virtual switch/button outputs
interface gpio_uart_sink_if;
    logic        rx_done;
    logic [7:0]  rx_data;
    logic        tx_done;
    logic        tx_we;
    logic [7:0]  tx_data;
    logic [15:0] sw;
    logic [4:0]  btn;
    logic        frame_ok;
    logic        frame_err;
    modport master(output rx_done, rx_data, tx_done,
                   input tx_we, tx_data, sw, btn, frame_ok, frame_err);
    modport slave(input rx_done, rx_data, tx_done,
                  output tx_we, tx_data, sw, btn, frame_ok, frame_err);
endinterface

// File: rtl/frame_timer.sv
// frame_timer: inter-byte silence counter, expires after TIMEOUT_CYCLES-1 idle cycles
module frame_timer #(
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);
    localparam int W = $clog2(TIMEOUT_CYCLES);
    localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);
    logic [W-1:0] r_cnt;
    always_ff @(posedge clk or posedge rst)
        if (rst) r_cnt <= '0;
        else     r_cnt <= (i_clr || !i_en) ? '0 : r_cnt + 1'b1;
    assign o_expired = i_en && (r_cnt == LAST);
endmodule

// File: rtl/gpio_uart_sink.sv
// gpio_uart_sink: parses HDR,B0,B1,B2,CK frames from the Uart into virtual sw/btn
// and answers every complete frame with one ACK/NAK byte.
module gpio_uart_sink
    import gpio_uart_pkg::*;
#(
    parameter int          TIMEOUT_CYCLES = 1_000_000,
    parameter logic [15:0] SW_RESET       = 16'h0000,
    parameter logic [4:0]  BTN_RESET      = 5'b00000
) (
    input logic clk,
    input logic rst,
    gpio_uart_sink_if.slave bus
);
    state_t      r_state;
    logic [1:0]  r_idx;
    logic [7:0]  r_shadow [PAYLOAD_BYTES];
    logic [15:0] r_sw;
    logic [4:0]  r_btn;
    logic        r_tx_we, r_ok, r_err;
    logic [7:0]  r_tx_data;
    logic        w_in_frame, w_expired;
    logic [7:0]  w_ck;

    assign w_in_frame = (r_state == PAYLOAD) || (r_state == CHECK);
    assign w_ck       = r_shadow[0] ^ r_shadow[1] ^ r_shadow[2];

    frame_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
        .clk       (clk),
        .rst       (rst),
        .i_clr     (bus.rx_done),
        .i_en      (w_in_frame),
        .o_expired (w_expired)
    );

    // A received byte always takes priority over a timeout on the same cycle.
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            r_state   <= IDLE;
            r_idx     <= '0;
            r_shadow  <= '{default: '0};
            r_sw      <= SW_RESET;
            r_btn     <= BTN_RESET;
            r_tx_we   <= 1'b0;
            r_tx_data <= '0;
            r_ok      <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_ok  <= 1'b0;
            r_err <= 1'b0;
            case (r_state)
                IDLE: if (bus.rx_done && bus.rx_data == HDR_BYTE) begin
                    r_state <= PAYLOAD;
                    r_idx   <= '0;
                end
                PAYLOAD:
                    if (bus.rx_done) begin
                        r_shadow[r_idx] <= bus.rx_data;
                        r_idx           <= r_idx + 1'b1;
                        if (r_idx == 2'(PAYLOAD_BYTES - 1)) r_state <= CHECK;
                    end else if (w_expired) begin
                        r_err   <= 1'b1;
                        r_state <= IDLE;
                    end
                CHECK:
                    if (bus.rx_done) begin
                        if (bus.rx_data == w_ck) begin
                            r_sw  <= {r_shadow[1], r_shadow[0]};
                            r_btn <= r_shadow[2][4:0];
                        end
                        r_ok      <= bus.rx_data == w_ck;
                        r_err     <= bus.rx_data != w_ck;
                        r_tx_data <= (bus.rx_data == w_ck) ? ACK_BYTE : NAK_BYTE;
                        r_tx_we   <= 1'b1;
                        r_state   <= SEND;
                    end else if (w_expired) begin
                        r_err   <= 1'b1;
                        r_state <= IDLE;
                    end
                SEND: begin
                    r_tx_we <= !bus.tx_done;
                    r_state <= bus.tx_done ? IDLE : WAIT;
                end
                WAIT: if (bus.tx_done) begin
                    r_tx_we <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end

    assign bus.sw        = r_sw;
    assign bus.btn       = r_btn;
    assign bus.tx_we     = r_tx_we;
    assign bus.tx_data   = r_tx_data;
    assign bus.frame_ok  = r_ok;
    assign bus.frame_err = r_err;
endmodule

// File: tb/tb_gpio_uart_sink.sv
// tb_gpio_uart_sink: directed and random byte streams checked against a frame-level model
module tb_gpio_uart_sink;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_chk = 0, n_pass = 0;
    int n_replies = 0, n_err_seen = 0;
    bit prev_we = 1'b0, auto_tx = 1'b0;

    bit          in_frame, busy;
    logic [7:0]  pay [$];
    int          quiet;
    logic [15:0] e_sw;
    logic [4:0]  e_btn;
    logic        e_ok, e_err, e_we;
    logic [7:0]  e_data;

    gpio_uart_sink_if bus();

    gpio_uart_sink #(
        .TIMEOUT_CYCLES(TO),
        .SW_RESET(16'h0000),
        .BTN_RESET(5'b00000)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        in_frame = 0; busy = 0; quiet = 0; pay.delete();
        e_sw = 16'h0000; e_btn = 5'b00000;
        e_ok = 0; e_err = 0; e_we = 0; e_data = 8'h00;
    endtask

    // Frame-level view: hunt for HDR, collect three payload bytes, judge the fourth.
    task automatic model_step(input bit rx, input logic [7:0] rd, input bit tx);
        logic [7:0] ck;
        e_ok = 0; e_err = 0;
        if (busy) begin
            if (tx) begin busy = 0; e_we = 0; end
        end else if (!in_frame) begin
            if (rx && rd == 8'h1c) begin in_frame = 1; pay.delete(); quiet = 0; end
        end else if (rx) begin
            quiet = 0;
            if (pay.size() < 3) pay.push_back(rd);
            else begin
                ck = pay[0] ^ pay[1] ^ pay[2];
                if (rd == ck) begin
                    e_sw = {pay[1], pay[0]}; e_btn = pay[2][4:0];
                    e_ok = 1; e_data = 8'h06;
                end else begin
                    e_err = 1; e_data = 8'h15;
                end
                e_we = 1; busy = 1; in_frame = 0;
            end
        end else begin
            quiet++;
            if (quiet == TO) begin e_err = 1; in_frame = 0; end
        end
    endtask

    task automatic check_all();
        chk("sw", bus.sw, e_sw);
        chk("btn", bus.btn, e_btn);
        chk("frame_ok", bus.frame_ok, e_ok);
        chk("frame_err", bus.frame_err, e_err);
        chk("tx_we", bus.tx_we, e_we);
        chk("tx_data", bus.tx_data, e_data);
    endtask

    function automatic bit txpol();
        return auto_tx && (bus.tx_we ? ($urandom % 3 == 0) : ($urandom % 16 == 0));
    endfunction

    task automatic step(input bit rx, input logic [7:0] rd, input bit tx);
        bus.rx_done = rx; bus.rx_data = rd; bus.tx_done = tx;
        @(posedge clk);
        model_step(rx, rd, tx);
        @(negedge clk);
        check_all();
        if (bus.tx_we && !prev_we) n_replies++;
        if (bus.frame_err) n_err_seen++;
        prev_we = bus.tx_we;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, txpol());
    endtask

    task automatic send_byte(input logic [7:0] b);
        step(1'b1, b, txpol());
        idle($urandom_range(0, 2));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.rx_done = 1'b0; bus.rx_data = 8'h00; bus.tx_done = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        rst = 1'b0;
        prev_we = 1'b0;
    endtask

    // Let the bench answer any outstanding reply, occasionally poking bytes that must be dropped.
    task automatic drain();
        int k = 0;
        auto_tx = 1'b1;
        while (bus.tx_we && k < 60) begin
            step($urandom % 4 == 0, 8'($urandom), txpol());
            k++;
        end
        chk("drain", bus.tx_we, 1'b0);
        idle(2);
    endtask

    initial begin
        bus.rx_done = 1'b0; bus.rx_data = 8'h00; bus.tx_done = 1'b0;
        do_reset();
        chk("reset_sw", bus.sw, 16'h0000);
        auto_tx = 1'b1;

        send_byte(8'h1c); send_byte(8'h34); send_byte(8'h12); send_byte(8'h15); send_byte(8'h33);
        drain();
        chk("ack_sw", bus.sw, 16'h1234);
        chk("ack_btn", bus.btn, 5'b10101);
        chk("ack_data", bus.tx_data, 8'h06);

        n_err_seen = 0;
        send_byte(8'h1c); send_byte(8'h34); send_byte(8'h12); send_byte(8'h15); send_byte(8'h00);
        drain();
        chk("nak_data", bus.tx_data, 8'h15);
        chk("nak_sw", bus.sw, 16'h1234);
        chk("nak_err", n_err_seen, 1);

        n_err_seen = 0; n_replies = 0;
        auto_tx = 1'b0;
        step(1'b1, 8'h1c, 1'b0); step(1'b1, 8'haa, 1'b0);
        idle(TO + 2);
        chk("to_err", n_err_seen, 1);
        chk("to_noreply", n_replies, 0);
        auto_tx = 1'b1;
        send_byte(8'h1c); send_byte(8'h01); send_byte(8'h00); send_byte(8'h00); send_byte(8'h01);
        drain();
        chk("after_to_sw", bus.sw, 16'h0001);
        chk("after_to_btn", bus.btn, 5'b00000);

        send_byte(8'h55); send_byte(8'h1c); send_byte(8'h1c); send_byte(8'h1c);
        send_byte(8'he0); send_byte(8'he0);
        drain();
        chk("hdr_data_sw", bus.sw, 16'h1c1c);
        chk("hdr_data_btn", bus.btn, 5'b00000);

        n_replies = 0;
        auto_tx = 1'b0;
        step(1'b1, 8'h1c, 1'b0); step(1'b1, 8'h34, 1'b0); step(1'b1, 8'h12, 1'b0);
        step(1'b1, 8'h15, 1'b0); step(1'b1, 8'h33, 1'b0);
        step(1'b1, 8'h1c, 1'b0); step(1'b1, 8'hff, 1'b0); step(1'b1, 8'hff, 1'b0);
        step(1'b1, 8'h1f, 1'b0); step(1'b1, 8'h1f, 1'b0);
        idle(3);
        drain();
        idle(TO + 2);
        chk("drop_sw", bus.sw, 16'h1234);
        chk("one_reply", n_replies, 1);

        send_byte(8'h1c); send_byte(8'h11);
        do_reset();
        chk("rst_payload_sw", bus.sw, 16'h0000);
        auto_tx = 1'b1;
        send_byte(8'h1c); send_byte(8'h22); send_byte(8'h33); send_byte(8'h04); send_byte(8'h15);
        drain();
        chk("post_rst_sw", bus.sw, 16'h3322);
        chk("post_rst_btn", bus.btn, 5'b00100);

        auto_tx = 1'b0;
        step(1'b1, 8'h1c, 1'b0); step(1'b1, 8'h78, 1'b0); step(1'b1, 8'h56, 1'b0);
        step(1'b1, 8'h0a, 1'b0); step(1'b1, 8'h24, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        do_reset();
        chk("rst_we", bus.tx_we, 1'b0);
        chk("rst_tx_sw", bus.sw, 16'h0000);
        auto_tx = 1'b1;
        send_byte(8'h1c); send_byte(8'h78); send_byte(8'h56); send_byte(8'h0a); send_byte(8'h24);
        drain();
        chk("rst_tx_recover", bus.sw, 16'h5678);

        for (int f = 0; f < 60; f++) begin
            int kind, n;
            logic [7:0] b0, b1, b2, ck;
            kind = $urandom % 5;
            b0 = 8'($urandom); b1 = 8'($urandom); b2 = 8'($urandom);
            ck = b0 ^ b1 ^ b2;
            if (kind == 4) send_byte(8'($urandom));
            if (kind == 3) begin
                n = $urandom_range(0, 3);
                send_byte(8'h1c);
                if (n > 0) send_byte(b0);
                if (n > 1) send_byte(b1);
                if (n > 2) send_byte(b2);
                idle(TO + $urandom_range(0, 2));
            end else begin
                send_byte(8'h1c); send_byte(b0); send_byte(b1);
                if ($urandom % 6 == 0) idle(TO - 1 + $urandom_range(0, 1));
                send_byte(b2);
                send_byte(kind == 2 ? ck ^ 8'($urandom_range(1, 255)) : ck);
            end
            drain();
            idle(TO + 1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/gpio_uart_sink.md
Name: gpio_uart_sink

Overview:
Host-to-board counterpart of the GPIO status reporter: parses command frames arriving as bytes from the Uart receiver and drives virtual switch/button inputs into the design under test. Validates each frame with an XOR checksum, updates outputs atomically, and answers each complete frame with one ACK/NAK byte through the Uart transmit handshake. Sits between the Uart instance and the user logic in the board wrapper.

Parameters:
TIMEOUT_CYCLES, 1_000_000, max clk cycles allowed between consecutive bytes of one frame before abort (must be >= 2)
SW_RESET, 16'h0000, value of sw after reset
BTN_RESET, 5'b00000, value of btn after reset

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  reset, asynchronous, active-high
rx_done  in  1  one-cycle pulse: rx_data holds a newly received byte
rx_data  in  8  received byte, valid when rx_done=1
tx_done  in  1  one-cycle pulse: Uart finished sending tx_data
tx_we  out  1  transmit request; held high until tx_done seen
tx_data  out  8  byte to transmit; stable while tx_we=1
sw  out  16  virtual switches
btn  out  5  virtual buttons
frame_ok  out  1  one-cycle pulse on accepted frame
frame_err  out  1  one-cycle pulse on checksum error or timeout

Behaviour:
- Frame: HDR(8'h1c), B0=sw[7:0], B1=sw[15:8], B2 (bits[4:0]=btn, bits[7:5] ignored), CK = B0^B1^B2.
- Reset (async, any state): state=IDLE, sw=SW_RESET, btn=BTN_RESET, tx_we=0, tx_data=0, frame_ok=0, frame_err=0, byte index=0, timer=0, shadow regs=0.
- States: IDLE, PAYLOAD, CHECK, SEND, WAIT.
- IDLE: rx_done & rx_data==HDR -> PAYLOAD, index=0, timer=0. Other bytes discarded.
- PAYLOAD: each rx_done stores rx_data into shadow[index]; index 2 -> CHECK. HDR value inside payload is plain data (no resync).
- CHECK: rx_done: rx_data==B0^B1^B2 -> sw/btn load from shadow on that same clock edge (visible next cycle), frame_ok pulses 1 cycle, tx_data=8'h06; else sw/btn unchanged, frame_err pulse, tx_data=8'h15. tx_we=1 same edge -> SEND.
- Timer: in PAYLOAD/CHECK increments every cycle without rx_done, cleared on rx_done; reaching TIMEOUT_CYCLES-1 -> frame_err pulse, IDLE, no reply, outputs unchanged. rx_done on the timeout cycle: byte wins, timer clears.
- SEND: tx_we=1, tx_data held; -> WAIT next cycle.
- WAIT: tx_done -> tx_we=0, IDLE. tx_done arriving in SEND is also accepted (-> IDLE directly).
- rx_done during SEND/WAIT: byte dropped, including HDR; host must wait for reply.
- tx_done outside SEND/WAIT ignored.
- Latency: CK byte rx_done at cycle N -> sw/btn/frame_ok/tx_we valid at N+1.
- frame_ok and frame_err never high together.

Decomposition:
- Package gpio_uart_pkg: HDR_BYTE=8'h1c, ACK_BYTE=8'h06, NAK_BYTE=8'h15, PAYLOAD_BYTES=3, state enum (IDLE, PAYLOAD, CHECK, SEND, WAIT).
- Sub-module frame_timer: counter with clear/enable inputs, expired output, parameter TIMEOUT_CYCLES; instantiated once.

Test Plan:
- Bytes 1c,34,12,15,33 -> sw=16'h1234, btn=5'b10101, frame_ok 1 pulse, tx_we with tx_data=06; after tx_done pulse tx_we=0, state IDLE.
- Bytes 1c,34,12,15,00 -> frame_err 1 pulse, tx_data=15, sw/btn keep previous values (16'h1234/10101).
- Bytes 1c,aa then silence for TIMEOUT_CYCLES (set to 16) -> frame_err pulse, no tx_we, IDLE; following 1c,01,00,00,01 -> sw=16'h0001, btn=0, ACK.
- Bytes 55,1c,1c,1c,e0,e0 (leading junk, HDR as payload, B2 upper bits set, CK=1c^1c^e0) -> sw=16'h1c1c, btn=0, ACK.
- During WAIT inject 1c,ff,ff,1f,1f before tx_done -> bytes dropped, sw unchanged, exactly one reply byte.
- Assert rst mid-PAYLOAD and while tx_we=1 -> outputs return to SW_RESET/BTN_RESET, tx_we=0 asynchronously; next full valid frame accepted normally.
